// File: rtl/image_window_gen.sv
// Sliding KxK window generator over a raster pixel stream, with K-1 line buffers,
// border handling (replicate or zero-fill) and a single registered output stage.
module image_window_gen #(
  parameter int unsigned DW          = 8,
  parameter int unsigned K           = 3,
  parameter int unsigned H_ACTIVE    = 1280,
  parameter int unsigned V_ACTIVE    = 720,
  parameter int unsigned BORDER_MODE = 0,
  parameter int unsigned EMIT_ALL    = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic                        i_sof,
  input  logic [DW-1:0]               i_data,
  output logic                        o_en,
  output logic [K*K*DW-1:0]           o_win,
  output logic [$clog2(H_ACTIVE)-1:0] o_x,
  output logic [$clog2(V_ACTIVE)-1:0] o_y,
  output logic                        o_sof
);

  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);
  localparam int          KI = int'(K);

  logic [XW-1:0]     h_q, h_d, cur_h;
  logic [YW-1:0]     v_q, v_d, cur_v;
  int                h_i, v_i;
  logic              emit, is_sof;

  logic [DW-1:0]     lb_q     [K-1][H_ACTIVE];
  logic [DW-1:0]     sr_q     [K-1][K];
  logic [DW-1:0]     raw_col  [K];
  logic [DW-1:0]     proc_col [K];
  logic [DW-1:0]     col_all  [K][K];
  logic [K*K*DW-1:0] win_d, win_q;

  logic              en_q, sof_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;

  // i_sof forces the current pixel to (0,0) regardless of where the counters are.
  always_comb begin
    cur_h = i_sof ? '0 : h_q;
    cur_v = i_sof ? '0 : v_q;
    h_d   = cur_h + XW'(1);
    v_d   = cur_v;
    if (cur_h == XW'(H_ACTIVE - 1)) begin
      h_d = '0;
      v_d = (cur_v == YW'(V_ACTIVE - 1)) ? '0 : cur_v + YW'(1);
    end
    h_i    = int'(cur_h);
    v_i    = int'(cur_v);
    emit   = (EMIT_ALL != 0) || (h_i >= KI - 1 && v_i >= KI - 1);
    is_sof = (EMIT_ALL != 0) ? (h_i == 0 && v_i == 0) : (h_i == KI - 1 && v_i == KI - 1);
  end

  // Cascaded line buffers: lb_q[0] holds row v-1, lb_q[K-2] holds row v-(K-1).
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      lb_q[0][cur_h] <= i_data;
      for (int j = 1; j < KI - 1; j++) begin
        lb_q[j][cur_h] <= lb_q[j-1][cur_h];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < KI - 1; r++) begin
      raw_col[r] = lb_q[KI-2-r][cur_h];
    end
    raw_col[KI-1] = i_data;

    // Rows above the frame top hold stale data; substitute row 0 or zero.
    for (int r = 0; r < KI; r++) begin
      proc_col[r] = raw_col[r];
      if (KI - 1 - r > v_i) begin
        proc_col[r] = '0;
        if (BORDER_MODE == 0) begin
          for (int s = 0; s < KI; s++) begin
            if (s == KI - 1 - v_i) proc_col[r] = raw_col[s];
          end
        end
      end
    end

    for (int c = 0; c < KI - 1; c++) begin
      col_all[c] = sr_q[c];
    end
    col_all[KI-1] = proc_col;

    // Columns left of the frame edge come from column 0 or are zero.
    win_d = '0;
    for (int r = 0; r < KI; r++) begin
      for (int c = 0; c < KI; c++) begin
        if (KI - 1 - c > h_i) begin
          if (BORDER_MODE == 0) begin
            for (int s = 0; s < KI; s++) begin
              if (s == KI - 1 - h_i) win_d[(r*KI+c)*DW +: DW] = col_all[s][r];
            end
          end
        end else begin
          win_d[(r*KI+c)*DW +: DW] = col_all[c][r];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_q   <= '0;
      v_q   <= '0;
      en_q  <= 1'b0;
      sof_q <= 1'b0;
      win_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      for (int c = 0; c < KI - 1; c++) begin
        for (int r = 0; r < KI; r++) begin
          sr_q[c][r] <= '0;
        end
      end
    end else begin
      en_q  <= i_en && emit;
      sof_q <= i_en && emit && is_sof;
      if (i_en) begin
        h_q <= h_d;
        v_q <= v_d;
        for (int c = 0; c < KI - 2; c++) begin
          sr_q[c] <= sr_q[c+1];
        end
        sr_q[KI-2] <= proc_col;
        if (emit) begin
          win_q <= win_d;
          x_q   <= cur_h;
          y_q   <= cur_v;
        end
      end
    end
  end

  assign o_en  = en_q;
  assign o_sof = sof_q;
  assign o_win = win_q;
  assign o_x   = x_q;
  assign o_y   = y_q;

endmodule

// File: tb/tb_image_window_gen.sv
// Directed bench for image_window_gen: three instances (replicate, zero-fill, K=5 inner-only)
// on an 8x6 image driven in lock step from one clock.
module tb_image_window_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en_a = 0, sof_a = 0, en_b = 0, sof_b = 0, en_c = 0, sof_c = 0;
  logic [7:0]  data_a = 0, data_b = 0, data_c = 0;
  logic        o_en_a, o_sof_a, o_en_b, o_sof_b, o_en_c, o_sof_c;
  logic [71:0] o_win_a, o_win_b;
  logic [199:0] o_win_c;
  logic [2:0]  o_x_a, o_y_a, o_x_b, o_y_b, o_x_c, o_y_c;

  image_window_gen #(.DW(8), .K(3), .H_ACTIVE(8), .V_ACTIVE(6), .BORDER_MODE(0), .EMIT_ALL(1))
    u_a (.i_clk(clk), .i_rst(rst), .i_en(en_a), .i_sof(sof_a), .i_data(data_a), .o_en(o_en_a),
         .o_win(o_win_a), .o_x(o_x_a), .o_y(o_y_a), .o_sof(o_sof_a));
  image_window_gen #(.DW(8), .K(3), .H_ACTIVE(8), .V_ACTIVE(6), .BORDER_MODE(1), .EMIT_ALL(1))
    u_b (.i_clk(clk), .i_rst(rst), .i_en(en_b), .i_sof(sof_b), .i_data(data_b), .o_en(o_en_b),
         .o_win(o_win_b), .o_x(o_x_b), .o_y(o_y_b), .o_sof(o_sof_b));
  image_window_gen #(.DW(8), .K(5), .H_ACTIVE(8), .V_ACTIVE(6), .BORDER_MODE(0), .EMIT_ALL(0))
    u_c (.i_clk(clk), .i_rst(rst), .i_en(en_c), .i_sof(sof_c), .i_data(data_c), .o_en(o_en_c),
         .o_win(o_win_c), .o_x(o_x_c), .o_y(o_y_c), .o_sof(o_sof_c));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic s);
    en_a = 1'b1; sof_a = s; data_a = d;
    tick();
    en_a = 1'b0; sof_a = 1'b0;
  endtask

  function automatic logic [71:0] w3(input logic [7:0] a00, a01, a02, a10, a11, a12,
                                     a20, a21, a22);
    return {a22, a21, a20, a12, a11, a10, a02, a01, a00};
  endfunction

  // Reference window for the 8x6 image, K=3, data = v*16+h+add, built from source coordinates.
  function automatic logic [71:0] ref3(input int mode, input int h, input int v, input int add);
    logic [71:0] w;
    int sh, sv;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        sh = h - 2 + c;
        sv = v - 2 + r;
        if (mode == 1 && (sh < 0 || sv < 0)) w[(r*3+c)*8 +: 8] = 8'h00;
        else w[(r*3+c)*8 +: 8] = 8'((sv < 0 ? 0 : sv) * 16 + (sh < 0 ? 0 : sh) + add);
      end
    end
    return w;
  endfunction

  typedef struct {
    int          sel;
    int          x;
    int          y;
    logic [71:0] win;
    logic        sof;
  } vec_t;

  vec_t        vt[10];
  logic [71:0] cw_a[48], cw_b[48];
  logic [2:0]  cx_a[48], cy_a[48], cx_b[48], cy_b[48];
  logic        ce_a[48], cs_a[48], ce_b[48], cs_b[48];

  initial begin
    int           idx, hh, vv, f;
    int           cnt[2], nsof;
    logic         seen[2], fsof[2];
    logic [2:0]   fx[2], fy[2];
    logic [199:0] fwin[2], exp5;
    logic [71:0]  save;

    vt[0] = '{0, 0, 0, w3(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1};
    vt[1] = '{0, 2, 2, w3(8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22), 1'b0};
    vt[2] = '{0, 1, 0, w3(8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01), 1'b0};
    vt[3] = '{0, 0, 1, w3(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10), 1'b0};
    vt[4] = '{0, 7, 5, w3(8'h35, 8'h36, 8'h37, 8'h45, 8'h46, 8'h47, 8'h55, 8'h56, 8'h57), 1'b0};
    vt[5] = '{1, 0, 0, w3(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01), 1'b1};
    vt[6] = '{1, 1, 1, w3(8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h11, 8'h12), 1'b0};
    vt[7] = '{1, 3, 0, w3(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03, 8'h04), 1'b0};
    vt[8] = '{1, 7, 5, w3(8'h36, 8'h37, 8'h38, 8'h46, 8'h47, 8'h48, 8'h56, 8'h57, 8'h58), 1'b0};
    vt[9] = '{0, 7, 0, w3(8'h05, 8'h06, 8'h07, 8'h05, 8'h06, 8'h07, 8'h05, 8'h06, 8'h07), 1'b0};

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_en", 256'(o_en_a), 256'(0));
    chk("rst_sof", 256'(o_sof_a), 256'(0));
    chk("rst_win", 256'(o_win_a), 256'(0));
    chk("rst_xy", 256'({o_x_a, o_y_a}), 256'(0));
    tick();
    tick();
    rst = 1'b0;

    // One full frame into A (data v*16+h) and B (data v*16+h+1)
    for (int p = 0; p < 48; p++) begin
      en_a = 1'b1; sof_a = (p == 0); data_a = 8'((p / 8) * 16 + p % 8);
      en_b = 1'b1; sof_b = (p == 0); data_b = 8'((p / 8) * 16 + p % 8 + 1);
      tick();
      cw_a[p] = o_win_a; cx_a[p] = o_x_a; cy_a[p] = o_y_a; ce_a[p] = o_en_a; cs_a[p] = o_sof_a;
      cw_b[p] = o_win_b; cx_b[p] = o_x_b; cy_b[p] = o_y_b; ce_b[p] = o_en_b; cs_b[p] = o_sof_b;
    end
    en_a = 1'b0; sof_a = 1'b0; en_b = 1'b0; sof_b = 1'b0;

    for (int i = 0; i < 10; i++) begin
      idx = vt[i].y * 8 + vt[i].x;
      if (vt[i].sel == 0) begin
        chk($sformatf("vec%0d_win", i), 256'(cw_a[idx]), 256'(vt[i].win));
        chk($sformatf("vec%0d_xy", i), 256'({cx_a[idx], cy_a[idx]}),
            256'({3'(vt[i].x), 3'(vt[i].y)}));
        chk($sformatf("vec%0d_sof", i), 256'(cs_a[idx]), 256'(vt[i].sof));
      end else begin
        chk($sformatf("vec%0d_win", i), 256'(cw_b[idx]), 256'(vt[i].win));
        chk($sformatf("vec%0d_xy", i), 256'({cx_b[idx], cy_b[idx]}),
            256'({3'(vt[i].x), 3'(vt[i].y)}));
        chk($sformatf("vec%0d_sof", i), 256'(cs_b[idx]), 256'(vt[i].sof));
      end
    end
    for (int p = 0; p < 48; p++) begin
      chk($sformatf("sweep_a_%0d", p), 256'({ce_a[p], cw_a[p]}), 256'({1'b1, ref3(0, p % 8, p / 8, 0)}));
      chk($sformatf("sweep_b_%0d", p), 256'({ce_b[p], cw_b[p]}), 256'({1'b1, ref3(1, p % 8, p / 8, 1)}));
    end

    // K=5 inner-only windows over two back-to-back frames
    cnt = '{0, 0}; seen = '{0, 0}; fsof = '{0, 0}; fx = '{0, 0}; fy = '{0, 0}; fwin = '{0, 0};
    nsof = 0;
    for (int p = 0; p < 96; p++) begin
      hh = p % 8; vv = (p / 8) % 6; f = p / 48;
      en_c = 1'b1; sof_c = (p == 0); data_c = 8'(vv * 16 + hh);
      tick();
      if (o_en_c) begin
        cnt[f]++;
        if (!seen[f]) begin
          seen[f] = 1'b1; fx[f] = o_x_c; fy[f] = o_y_c; fsof[f] = o_sof_c; fwin[f] = o_win_c;
        end
      end
      if (o_sof_c) nsof++;
    end
    en_c = 1'b0; sof_c = 1'b0;
    exp5 = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) exp5[(r*5+c)*8 +: 8] = 8'(r * 16 + c);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("k5_cnt_f%0d", i), 256'(cnt[i]), 256'(8));
      chk($sformatf("k5_first_xy_f%0d", i), 256'({fx[i], fy[i]}), 256'({3'd4, 3'd4}));
      chk($sformatf("k5_first_sof_f%0d", i), 256'(fsof[i]), 256'(1));
      chk($sformatf("k5_first_win_f%0d", i), 256'(fwin[i]), 256'(exp5));
    end
    chk("k5_sof_total", 256'(nsof), 256'(2));

    // Stall for 5 cycles after (3,2), then (4,2)
    for (int p = 0; p < 20; p++) send_a(8'((p / 8) * 16 + p % 8), p == 0);
    save = o_win_a;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d_en", i), 256'(o_en_a), 256'(0));
      chk($sformatf("stall%0d_win", i), 256'(o_win_a), 256'(save));
    end
    send_a(8'h24, 1'b0);
    chk("after_stall_win", 256'(o_win_a),
        256'(w3(8'h02, 8'h03, 8'h04, 8'h12, 8'h13, 8'h14, 8'h22, 8'h23, 8'h24)));
    chk("after_stall_xy_en", 256'({o_en_a, o_x_a, o_y_a}), 256'({1'b1, 3'd4, 3'd2}));

    // i_sof arriving with the counters at (3,1)
    for (int p = 0; p < 11; p++) send_a(8'((p / 8) * 16 + p % 8), p == 0);
    send_a(8'h77, 1'b1);
    chk("midsof_flags", 256'({o_en_a, o_sof_a, o_x_a, o_y_a}), 256'({1'b1, 1'b1, 3'd0, 3'd0}));
    chk("midsof_win", 256'(o_win_a),
        256'(w3(8'h77, 8'h77, 8'h77, 8'h77, 8'h77, 8'h77, 8'h77, 8'h77, 8'h77)));
    send_a(8'h78, 1'b0);
    chk("midsof_next_win", 256'(o_win_a),
        256'(w3(8'h77, 8'h77, 8'h78, 8'h77, 8'h77, 8'h78, 8'h77, 8'h77, 8'h78)));
    chk("midsof_next_flags", 256'({o_sof_a, o_x_a, o_y_a}), 256'({1'b0, 3'd1, 3'd0}));

    // Reset mid-row
    send_a(8'h79, 1'b0);
    send_a(8'h7a, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_en_sof", 256'({o_en_a, o_sof_a}), 256'(0));
    chk("midrst_win", 256'(o_win_a), 256'(0));
    chk("midrst_xy", 256'({o_x_a, o_y_a}), 256'(0));
    tick();
    rst = 1'b0;
    send_a(8'h55, 1'b0);
    chk("postrst_flags", 256'({o_en_a, o_sof_a, o_x_a, o_y_a}), 256'({1'b1, 1'b1, 3'd0, 3'd0}));
    chk("postrst_win", 256'(o_win_a),
        256'(w3(8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/image_window_gen.md
IMAGE_WINDOW_GEN -- requirements
Module: image_window_gen

Interface
REQ-001 SHALL have parameter DW, default 8, pixel width in bits.
REQ-002 SHALL have parameter K, default 3, window size; legal values are 3 and 5 only.
REQ-003 SHALL have parameter H_ACTIVE, default 1280, pixels per line.
REQ-004 SHALL have parameter V_ACTIVE, default 720, lines per frame.
REQ-005 SHALL have parameter BORDER_MODE, default 0: 0 = replicate nearest valid pixel, 1 = zero fill.
REQ-006 SHALL have parameter EMIT_ALL, default 0: 1 = emit a window for every input pixel, 0 = emit only windows lying fully inside the image.
REQ-007 SHALL have port i_clk, input, 1 bit, the only clock; all logic on its rising edge.
REQ-008 SHALL have port i_rst, input, 1 bit, asynchronous, active-high reset.
REQ-009 SHALL have port i_en, input, 1 bit, input pixel valid.
REQ-010 SHALL have port i_sof, input, 1 bit, frame start, qualified by i_en.
REQ-011 SHALL have port i_data, input, DW bits, input pixel, raster order.
REQ-012 SHALL have port o_en, output, 1 bit, window valid.
REQ-013 SHALL have port o_win, output, K*K*DW bits; element (r,c) at bits [(r*K+c)*DW +: DW], r=0 oldest row, c=0 oldest column.
REQ-014 SHALL have ports o_x and o_y, outputs, $clog2(H_ACTIVE) and $clog2(V_ACTIVE) bits, coordinates of the newest pixel in the window.
REQ-015 SHALL have port o_sof, output, 1 bit, high with the first o_en of each frame.

Function
REQ-016 SHALL track column h and row v of each accepted pixel (i_en=1): h wraps H_ACTIVE-1 -> 0 and increments v; v wraps V_ACTIVE-1 -> 0.
REQ-017 SHALL, on i_en=1 with i_sof=1, treat the current pixel as (0,0) regardless of counter state; i_sof with i_en=0 is ignored.
REQ-018 SHALL keep K-1 internal line buffers of depth H_ACTIVE, so rows v-1 .. v-(K-1) at column h are available when pixel (h,v) arrives.
REQ-019 SHALL anchor the window at the newest pixel: element (r,c) = pixel(h-(K-1)+c, v-(K-1)+r); element (K-1,K-1) is i_data of the accepted pixel.
REQ-020 SHALL, for BORDER_MODE=0, clamp source coordinates below 0 to 0, per axis independently.
REQ-021 SHALL, for BORDER_MODE=1, output 0 for every element whose source row or column is below 0.
REQ-022 SHALL never use line-buffer or column contents from a previous frame or from before reset; border rules replace them.
REQ-023 SHALL have a latency of exactly 1 cycle: accepted pixel at edge N gives o_en, o_win, o_x, o_y and o_sof valid after edge N+1.
REQ-024 SHALL assert o_en for one cycle per accepted pixel when EMIT_ALL=1; when EMIT_ALL=0, only when h>=K-1 and v>=K-1.
REQ-025 SHALL assert o_sof on the first o_en whose window belongs to a new frame: (0,0) if EMIT_ALL=1, (K-1,K-1) if EMIT_ALL=0.
REQ-026 SHALL freeze all state when i_en=0, with o_en=0 and o_win/o_x/o_y holding their last values; stalls of any length and position are legal.
REQ-027 SHALL accept a new frame after (H_ACTIVE-1,V_ACTIVE-1) without i_sof, continuing back to back with no idle cycle required.

Reset
REQ-028 SHALL, while i_rst=1, force o_en=0, o_sof=0, o_win=0, o_x=0, o_y=0 and h=v=0, asynchronously.
REQ-029 SHALL treat the first accepted pixel after reset release as (0,0) of a new frame; a reset mid-frame discards the partial frame.

Verification
REQ-030 SHALL cover: i_rst=1 mid-row -> o_en=0, o_win=0, o_x=o_y=0 immediately; next pixel after release gives o_x=0, o_y=0, o_sof=1 (EMIT_ALL=1).
REQ-031 SHALL cover: H=8, V=6, K=3, mode 0, EMIT_ALL=1, data=v*16+h -> at (0,0) all nine elements 0x00; at (2,2) rows [00,01,02],[10,11,12],[20,21,22]; at (1,0) every row [00,00,01].
REQ-032 SHALL cover: same image, BORDER_MODE=1, data=v*16+h+1 -> at (0,0) only element (2,2)=0x01, all others 0; at (1,1) rows [00,00,00],[00,01,02],[00,11,12].
REQ-033 SHALL cover: EMIT_ALL=0, K=5, 8x6 image over two back-to-back frames -> exactly 8 o_en per frame, the first with o_x=4, o_y=4, o_sof=1.
REQ-034 SHALL cover: i_en low for 5 cycles at (3,2) -> o_en=0 and o_win unchanged during the gap, then the (4,2) window is correct.
REQ-035 SHALL cover: i_sof with i_en at counter state (3,1) -> output o_x=0, o_y=0, o_sof=1, with the window built by the border rule as for (0,0).
